axi_sram_slave: RTL
===================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 16384, meaning the number of 32-bit words of backing storage (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address mapped to word 0.
REQ-003 SHALL have ports `ACLK  in  1  clock` and `ARESET  in  1  reset`; reset is asynchronous and active-high.
REQ-004 SHALL have write-address ports AWID in 8, AWADDR in 32, AWLEN in 4, AWSIZE in 3, AWBURST in 2, AWVALID in 1, and AWREADY out 1.
REQ-005 SHALL have write-data ports WDATA in 32, WSTRB in 4, WLAST in 1, WVALID in 1, and WREADY out 1.
REQ-006 SHALL have write-response ports BID out 8, BRESP out 2, BVALID out 1, and BREADY in 1.
REQ-007 SHALL have read-address ports ARID in 8, ARADDR in 32, ARLEN in 4, ARSIZE in 3, ARBURST in 2, ARVALID in 1, and ARREADY out 1.
REQ-008 SHALL have read-data ports RID out 8, RDATA out 32, RRESP out 2, RLAST out 1, RVALID out 1, and RREADY in 1.

Function
REQ-009 SHALL use one FSM with the states IDLE, WDATA, WRESP, RADDR and RDATA, because the read and write paths share a single-port memory.
REQ-010 In IDLE, SHALL assert AWREADY and ARREADY combinationally when the other channel is not winning; if AWVALID and ARVALID are both high, the write wins when the last serviced transaction was a read, otherwise the read wins (alternating priority).
REQ-011 On an AW handshake, SHALL latch ID, address and LEN, clear the beat counter, and go to WDATA.
REQ-012 In WDATA, SHALL hold WREADY high; each W handshake writes the byte lanes with WSTRB bit i set into the word at the current address, then increments the address by 4.
REQ-013 SHALL compare the beat counter with the latched LEN (LEN+1 beats, maximum 16); on the beat where counter==LEN, SHALL go to WRESP regardless of WLAST.
REQ-014 On a WLAST/counter mismatch, SHALL flag BRESP=SLVERR for that burst and SHALL NOT store any data beat after counter==LEN.
REQ-015 In WRESP, SHALL hold BVALID high with BID equal to the latched ID; BID, BRESP and BVALID stay stable until BREADY, and the FSM returns to IDLE on the cycle after the handshake.
REQ-016 On an AR handshake, SHALL latch ID, address and LEN and go to RADDR; RADDR issues a synchronous memory read (1-cycle latency), then the FSM goes to RDATA.
REQ-017 In RDATA, SHALL drive RVALID high, RDATA from the memory, RID from the latched ID, and RLAST high exactly when counter==LEN.
REQ-018 SHALL hold RDATA stable while RVALID=1 and RREADY=0; the next-address prefetch starts only after the R handshake.
REQ-019 SHALL make the first RVALID appear 2 cycles after the AR handshake, and subsequent beats 2 cycles after each R handshake.
REQ-020 After the RLAST handshake, SHALL return to IDLE.
REQ-021 SHALL treat every burst as INCR with 4-byte beats; AWSIZE, ARSIZE, AWBURST and ARBURST are ignored.
REQ-022 SHALL let the address increment wrap modulo MEM_WORDS.
REQ-023 SHALL never assert AWREADY or ARREADY outside IDLE.

Reset
REQ-024 While ARESET=1, SHALL hold the FSM in IDLE and AWREADY, WREADY, ARREADY, BVALID, RVALID and RLAST at 0, with BID=0, RID=0, BRESP=OKAY, RRESP=OKAY and RDATA=0.
REQ-025 SHALL leave the memory contents unchanged by reset.
REQ-026 If reset is asserted mid-burst, SHALL abandon the burst immediately with no response issued; any partially written beats remain in memory.

Configuration
REQ-027 With AXI_SLV_ERR_EN defined, an address outside BASE_ADDR..BASE_ADDR+4*MEM_WORDS-1 SHALL be accepted and fully handshaken, SHALL suppress all memory writes, SHALL return RDATA=0, and SHALL return BRESP or RRESP=SLVERR (2'b10) on every beat.
REQ-028 Without AXI_SLV_ERR_EN, SHALL index memory by the address bits [log2(MEM_WORDS)+1:2] and return OKAY on every response, except per REQ-014.

Structure
REQ-029 The shared package axi_pkg SHALL hold the width constants (ID 8, ADDR 32, DATA 32, STRB 4, LEN 4, SIZE 3), the response codes OKAY=2'b00 and SLVERR=2'b10, and the slave FSM state enum.
REQ-030 The storage SHALL be one sub-module, sram_1rw (single port, synchronous read, per-byte write enables).

Verification
REQ-031 Single write of AWADDR=0x10, LEN=0, WDATA=0xDEADBEEF, WSTRB=4'hF, followed by a read of 0x10 -> BID equals AWID, BRESP=0, and RDATA=0xDEADBEEF with RLAST=1.
REQ-032 A 4-beat write burst at 0x100 of 1,2,3,4 with WSTRB=4'b0011 on beat 2 over old data 0xFFFFFFFF, then a 4-beat read -> the read returns 1, 0xFFFF0002, 3, 4, with RLAST only on beat 4.
REQ-033 A read burst LEN=3 with RREADY held low for 5 cycles on beat 1 -> RDATA and RID stay stable, and no beat is lost or duplicated.
REQ-034 AWVALID and ARVALID asserted in the same cycle twice back-to-back -> the grants alternate in the order write, read, write, read (last serviced was a read, from reset).
REQ-035 With AXI_SLV_ERR_EN, a write then a read at BASE_ADDR+0x10000 (MEM_WORDS=16384) -> BRESP=2'b10, RRESP=2'b10 and RDATA=0, and the contents at address 0x0 are unchanged.
REQ-036 ARESET pulsed during beat 2 of an 8-beat write -> all outputs return to reset values asynchronously, and the next single read at that burst's base address returns beat 1's data.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI constants, response codes and the slave FSM state encoding.
package axi_pkg;

    localparam int ID_W   = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;
    localparam int LEN_W  = 4;
    localparam int SIZE_W = 3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WDATA = 3'd1,
        ST_WRESP = 3'd2,
        ST_RADDR = 3'd3,
        ST_RDATA = 3'd4
    } slv_state_e;

endpackage

// File: rtl/sram_1rw.sv
// Single-port SRAM: synchronous read (1-cycle latency), per-byte write enables.
// Contents are never reset; a read happens on any enabled cycle with no byte enable set.
module sram_1rw #(
    parameter int WORDS = 16384,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
            if (we_i == 4'b0000) begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3-style burst slave in front of a single-port SRAM; one FSM serialises reads and writes.
// Optional macro AXI_SLV_ERR_EN: out-of-range addresses answer SLVERR and never touch memory.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int          MEM_WORDS = 16384,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ID_W-1:0]   AWID,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [LEN_W-1:0]  AWLEN,
    input  logic [SIZE_W-1:0] AWSIZE,
    input  logic [1:0]        AWBURST,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [STRB_W-1:0] WSTRB,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [ID_W-1:0]   BID,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [ID_W-1:0]   ARID,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [LEN_W-1:0]  ARLEN,
    input  logic [SIZE_W-1:0] ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [ID_W-1:0]   RID,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    output logic [2:0]        dbg_state_o
);

    localparam int AW = $clog2(MEM_WORDS);

    slv_state_e        state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d, cnt_q, cnt_d;
    logic [1:0]        resp_q, resp_d;
    logic              err_q, err_d;
    logic              last_rd_q, last_rd_d;

    logic              mem_en;
    logic [3:0]        mem_we;
    logic [31:0]       mem_rdata;
    logic              idle, aw_rdy, ar_rdy;
    logic              aw_oob, ar_oob;
    logic [AW-1:0]     aw_idx, ar_idx;
    logic              unused_inputs;

`ifdef AXI_SLV_ERR_EN
    logic [31:0] aw_off, ar_off;
    assign aw_off = AWADDR - BASE_ADDR;
    assign ar_off = ARADDR - BASE_ADDR;
    assign aw_oob = (aw_off >> (AW + 2)) != 32'd0;
    assign ar_oob = (ar_off >> (AW + 2)) != 32'd0;
    assign aw_idx = aw_off[AW+1:2];
    assign ar_idx = ar_off[AW+1:2];
`else
    assign aw_oob = 1'b0;
    assign ar_oob = 1'b0;
    assign aw_idx = AWADDR[AW+1:2];
    assign ar_idx = ARADDR[AW+1:2];
`endif

    assign unused_inputs = ^{AWSIZE, AWBURST, ARSIZE, ARBURST, AWADDR, ARADDR, BASE_ADDR};

    // Alternating priority: a simultaneous request goes to the channel not serviced last.
    assign idle    = (state_q == ST_IDLE) && !ARESET;
    assign aw_rdy  = idle && !(ARVALID && !last_rd_q);
    assign ar_rdy  = idle && !(AWVALID && last_rd_q);
    assign AWREADY = aw_rdy;
    assign ARREADY = ar_rdy;
    assign dbg_state_o = state_q;

    sram_1rw #(.WORDS(MEM_WORDS), .AW(AW)) u_sram (
        .clk_i   (ACLK),
        .en_i    (mem_en),
        .we_i    (mem_we),
        .addr_i  (addr_q),
        .wdata_i (WDATA),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q   <= ST_IDLE;
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            resp_q    <= RESP_OKAY;
            err_q     <= 1'b0;
            last_rd_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            resp_q    <= resp_d;
            err_q     <= err_d;
            last_rd_q <= last_rd_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        addr_d    = addr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        resp_d    = resp_q;
        err_d     = err_q;
        last_rd_d = last_rd_q;
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        WREADY    = 1'b0;
        BVALID    = 1'b0;
        BID       = '0;
        BRESP     = RESP_OKAY;
        RVALID    = 1'b0;
        RID       = '0;
        RDATA     = '0;
        RRESP     = RESP_OKAY;
        RLAST     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (AWVALID && aw_rdy) begin
                    id_d      = AWID;
                    addr_d    = aw_idx;
                    len_d     = AWLEN;
                    cnt_d     = '0;
                    err_d     = aw_oob;
                    resp_d    = aw_oob ? RESP_SLVERR : RESP_OKAY;
                    last_rd_d = 1'b0;
                    state_d   = ST_WDATA;
                end else if (ARVALID && ar_rdy) begin
                    id_d      = ARID;
                    addr_d    = ar_idx;
                    len_d     = ARLEN;
                    cnt_d     = '0;
                    err_d     = ar_oob;
                    resp_d    = ar_oob ? RESP_SLVERR : RESP_OKAY;
                    last_rd_d = 1'b1;
                    state_d   = ST_RADDR;
                end
            end
            ST_WDATA: begin
                WREADY = 1'b1;
                if (WVALID) begin
                    mem_en = !err_q;
                    mem_we = err_q ? 4'b0000 : WSTRB;
                    addr_d = addr_q + AW'(1);
                    cnt_d  = cnt_q + 4'd1;
                    // The beat count, not WLAST, ends the burst; disagreement only taints BRESP.
                    if (WLAST != (cnt_q == len_q)) begin
                        resp_d = RESP_SLVERR;
                    end
                    if (cnt_q == len_q) begin
                        state_d = ST_WRESP;
                    end
                end
            end
            ST_WRESP: begin
                BVALID = 1'b1;
                BID    = id_q;
                BRESP  = resp_q;
                if (BREADY) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RADDR: begin
                mem_en  = 1'b1;
                state_d = ST_RDATA;
            end
            ST_RDATA: begin
                RVALID = 1'b1;
                RID    = id_q;
                RRESP  = resp_q;
                RDATA  = err_q ? 32'd0 : mem_rdata;
                RLAST  = (cnt_q == len_q);
                // The SRAM output register is only re-read after the handshake, so RDATA holds.
                if (RREADY) begin
                    if (cnt_q == len_q) begin
                        state_d = ST_IDLE;
                    end else begin
                        addr_d  = addr_q + AW'(1);
                        cnt_d   = cnt_q + 4'd1;
                        state_d = ST_RADDR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule
